// File: rtl/weight_fifo_pkg.sv
// Shared types and sizing helpers for the weight FIFO sequencer.
package weight_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned FIFO_WIDTH_DEF = 16;
   localparam int unsigned FIFO_DEPTH_DEF = 16;
   localparam int unsigned TILE_CNT_W_DEF = 8;
   localparam int unsigned PERF_W         = 32;

   // Counter width for a modulus n; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/weight_fifo_seq_if.sv
// Weight stream and FIFO-bank control bundle; master is the sequencer side.
interface weight_fifo_seq_if
   import weight_fifo_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

   localparam int unsigned ROW_W = cnt_w(FIFO_DEPTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [FIFO_WIDTH-1:0] col_wen;
   logic [ROW_W-1:0]      row_idx;
   logic                  drain_stall;
   logic [FIFO_WIDTH-1:0] fifo_en;
   logic [FIFO_WIDTH-1:0] w_wen;

   modport master (
      input  in_valid, drain_stall,
      output in_ready, col_wen, row_idx, fifo_en, w_wen
   );

   modport slave (
      output in_valid, drain_stall,
      input  in_ready, col_wen, row_idx, fifo_en, w_wen
   );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-MAX counter with synchronous clear and a same-cycle wrap pulse.
module wrap_counter
   import weight_fifo_pkg::*;
#(
   parameter  int unsigned MAX = 16,
   localparam int unsigned W   = cnt_w(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         wrap_c
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         at_max;

   assign at_max = (count_q == W'(MAX - 1));

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = at_max ? '0 : count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign wrap_c = en && at_max;

endmodule

// File: rtl/weight_fifo_seq.sv
// Weight FIFO tile sequencer: column-major fill, lockstep drain, per-tile repeat.
// Optional stall counters are built when WEIGHT_FIFO_SEQ_PERF_EN is defined.
module weight_fifo_seq
   import weight_fifo_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned TILE_CNT_W = TILE_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [TILE_CNT_W-1:0] num_tiles,
   output logic                  busy,
   output logic                  done,
   output logic [TILE_CNT_W-1:0] tile_idx,
   weight_fifo_seq_if.master     wif
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
   ,
   output logic [PERF_W-1:0]     fill_stall_cycles,
   output logic [PERF_W-1:0]     drain_stall_cycles
`endif
);

   localparam int unsigned ROW_W    = cnt_w(FIFO_DEPTH);
   localparam int unsigned COL_W    = cnt_w(FIFO_WIDTH);
   localparam int unsigned TILE_MAX = 1 << TILE_CNT_W;

   state_e                state_q, state_d;
   logic [TILE_CNT_W-1:0] num_tiles_q, num_tiles_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;

   logic                  fill_hs_c, drain_go_c, start_acc_c, tile_inc_c, last_tile_c;
   logic [ROW_W-1:0]      row_cnt;
   logic [COL_W-1:0]      col_cnt;
   logic [ROW_W-1:0]      drain_cnt_unused;
   logic [TILE_CNT_W-1:0] tile_cnt;
   logic                  row_wrap, col_wrap, drain_wrap, tile_wrap_unused;

   logic                  in_ready_c;
   logic [FIFO_WIDTH-1:0] col_wen_c, fifo_en_c, w_wen_c;

   assign fill_hs_c   = (state_q == FILL) && wif.in_valid;
   assign drain_go_c  = (state_q == DRAIN) && !wif.drain_stall;
   assign last_tile_c = (tile_cnt == num_tiles_q - TILE_CNT_W'(1));

   // Row advances per handshake; column advances when a row pass completes.
   wrap_counter #(.MAX(FIFO_DEPTH)) u_row_cnt (
      .clk(clk), .rst(rst), .en(fill_hs_c), .clr(start_acc_c),
      .count(row_cnt), .wrap_c(row_wrap)
   );

   wrap_counter #(.MAX(FIFO_WIDTH)) u_col_cnt (
      .clk(clk), .rst(rst), .en(row_wrap), .clr(start_acc_c),
      .count(col_cnt), .wrap_c(col_wrap)
   );

   wrap_counter #(.MAX(FIFO_DEPTH)) u_drain_cnt (
      .clk(clk), .rst(rst), .en(drain_go_c), .clr(start_acc_c),
      .count(drain_cnt_unused), .wrap_c(drain_wrap)
   );

   wrap_counter #(.MAX(TILE_MAX)) u_tile_cnt (
      .clk(clk), .rst(rst), .en(tile_inc_c), .clr(start_acc_c),
      .count(tile_cnt), .wrap_c(tile_wrap_unused)
   );

   // Next-state and run bookkeeping.
   always_comb begin
      state_d     = state_q;
      num_tiles_d = num_tiles_q;
      done_d      = 1'b0;
      start_acc_c = 1'b0;
      tile_inc_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_tiles != '0) begin
                  state_d     = FILL;
                  num_tiles_d = num_tiles;
                  start_acc_c = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FILL: begin
            if (col_wrap) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_wrap) begin
               if (last_tile_c) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = FILL;
                  tile_inc_c = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         num_tiles_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         num_tiles_q <= num_tiles_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Bank-side strobes decode from registered state and the live handshake inputs.
   always_comb begin
      in_ready_c = 1'b0;
      col_wen_c  = '0;
      fifo_en_c  = '0;
      w_wen_c    = '0;
      if (state_q == FILL) begin
         in_ready_c = 1'b1;
      end
      if (fill_hs_c) begin
         col_wen_c = FIFO_WIDTH'(1) << col_cnt;
      end
      if (drain_go_c) begin
         fifo_en_c = '1;
         w_wen_c   = '1;
      end
   end

   assign wif.in_ready = in_ready_c;
   assign wif.col_wen  = col_wen_c;
   assign wif.row_idx  = row_cnt;
   assign wif.fifo_en  = fifo_en_c;
   assign wif.w_wen    = w_wen_c;
   assign busy         = busy_q;
   assign done         = done_q;
   assign tile_idx     = tile_cnt;

`ifdef WEIGHT_FIFO_SEQ_PERF_EN
   logic [PERF_W-1:0] fill_stall_cnt_q, fill_stall_cnt_d;
   logic [PERF_W-1:0] drain_stall_cnt_q, drain_stall_cnt_d;

   // Saturating stall counters, cleared when a run is accepted.
   always_comb begin
      fill_stall_cnt_d  = fill_stall_cnt_q;
      drain_stall_cnt_d = drain_stall_cnt_q;
      if (start_acc_c) begin
         fill_stall_cnt_d  = '0;
         drain_stall_cnt_d = '0;
      end else begin
         if ((state_q == FILL) && !wif.in_valid && (fill_stall_cnt_q != '1)) begin
            fill_stall_cnt_d = fill_stall_cnt_q + PERF_W'(1);
         end
         if ((state_q == DRAIN) && wif.drain_stall && (drain_stall_cnt_q != '1)) begin
            drain_stall_cnt_d = drain_stall_cnt_q + PERF_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_stall_cnt_q  <= '0;
         drain_stall_cnt_q <= '0;
      end else begin
         fill_stall_cnt_q  <= fill_stall_cnt_d;
         drain_stall_cnt_q <= drain_stall_cnt_d;
      end
   end

   assign fill_stall_cycles  = fill_stall_cnt_q;
   assign drain_stall_cycles = drain_stall_cnt_q;
`endif

endmodule

// File: tb/tb_weight_fifo_seq.sv
// Directed bench for weight_fifo_seq (W=4, D=4) with a handshake scoreboard.
module tb_weight_fifo_seq;
   import weight_fifo_pkg::*;

   localparam int unsigned W  = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned TW = 8;

   typedef struct packed {
      logic [TW-1:0] tile;
      logic [W-1:0]  col_oh;
      logic [1:0]    row;
   } hs_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [TW-1:0] num_tiles;
   logic          busy;
   logic          done;
   logic [TW-1:0] tile_idx;
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
   logic [31:0]   fsc;
   logic [31:0]   dsc;
`endif

   weight_fifo_seq_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) wif ();

   weight_fifo_seq #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .TILE_CNT_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .num_tiles (num_tiles),
      .busy      (busy),
      .done      (done),
      .tile_idx  (tile_idx),
      .wif       (wif)
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
      ,
      .fill_stall_cycles  (fsc),
      .drain_stall_cycles (dsc)
`endif
   );

   always #5 clk = ~clk;

   int  tests  = 0;
   int  failed = 0;
   hs_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full run: start, per-cycle scoreboard checks, end-of-run totals.
   task automatic do_run(input int nt, input bit toggle, input int stall_after,
                         input int stall_len, input bit poke_start, input int exp_done_k);
      int  hs = 0;
      int  drains = 0;
      int  stall_left = 0;
      int  done_k = 0;
      bit  saw_done = 1'b0;
      hs_t e;
      exp_q.delete();
      for (int t = 0; t < nt; t++)
         for (int c = 0; c < int'(W); c++)
            for (int r = 0; r < int'(D); r++)
               exp_q.push_back('{tile: TW'(t), col_oh: W'(1 << c), row: 2'(r)});
      start     = 1'b1;
      num_tiles = TW'(nt);
      @(posedge clk); #1;
      for (int k = 1; k <= 600 && !saw_done; k++) begin
         wif.in_valid    = toggle ? (k % 2 == 0) : 1'b1;
         wif.drain_stall = (stall_left > 0);
         if (poke_start && k == 5) begin
            start     = 1'b1;
            num_tiles = 8'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (k == 1) chk("busy_after_start", 64'(busy), 64'd1);
         if (wif.in_valid && wif.in_ready) begin
            if (exp_q.size() == 0) begin
               chk("hs_overrun", 64'(hs + 1), 64'(nt * int'(W * D)));
            end else begin
               e = exp_q.pop_front();
               chk("col_wen", 64'(wif.col_wen), 64'(e.col_oh));
               chk("row_idx", 64'(wif.row_idx), 64'(e.row));
               chk("tile_idx_fill", 64'(tile_idx), 64'(e.tile));
               chk("fifo_en_in_fill", 64'(wif.fifo_en), 64'd0);
            end
            hs++;
         end else if (wif.in_ready) begin
            chk("col_wen_idle", 64'(wif.col_wen), 64'd0);
         end
         if (busy && !wif.in_ready) begin
            if (wif.drain_stall) begin
               chk("fifo_en_stall", 64'(wif.fifo_en), 64'd0);
               chk("w_wen_stall", 64'(wif.w_wen), 64'd0);
               stall_left--;
            end else begin
               chk("fifo_en_drain", 64'(wif.fifo_en), 64'hF);
               chk("w_wen_drain", 64'(wif.w_wen), 64'hF);
               chk("drain_after_fill", 64'(hs), 64'((drains / int'(D) + 1) * int'(W * D)));
               drains++;
               if (stall_after > 0 && drains == stall_after) stall_left = stall_len;
            end
         end
         if (done) begin
            saw_done = 1'b1;
            done_k   = k;
            chk("busy_at_done", 64'(busy), 64'd0);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("done_seen", 64'(saw_done), 64'd1);
      chk("hs_total", 64'(hs), 64'(nt * int'(W * D)));
      chk("drain_total", 64'(drains), 64'(nt * int'(D)));
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      if (exp_done_k > 0) chk("done_latency", 64'(done_k), 64'(exp_done_k));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      bit found = 1'b0;
      rst             = 1'b1;
      start           = 1'b0;
      num_tiles       = '0;
      wif.in_valid    = 1'b1;
      wif.drain_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_in_ready", 64'(wif.in_ready), 64'd0);
      chk("rst_col_wen", 64'(wif.col_wen), 64'd0);
      chk("rst_fifo_en", 64'(wif.fifo_en), 64'd0);
      chk("rst_tile_idx", 64'(tile_idx), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Zero-tile request: no run, done one cycle later.
      start     = 1'b1;
      num_tiles = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("zero_busy", 64'(busy), 64'd0);
      chk("zero_done", 64'(done), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("zero_done_clear", 64'(done), 64'd0);
      chk("zero_busy_after", 64'(busy), 64'd0);
      @(posedge clk); #1;

      do_run(2, 1'b0, 0, 0, 1'b0, 41);
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
      chk("perf_fill_cont", 64'(fsc), 64'd0);
      chk("perf_drain_cont", 64'(dsc), 64'd0);
`endif
      do_run(2, 1'b1, 0, 0, 1'b0, 73);
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
      chk("perf_fill_toggle", 64'(fsc), 64'd32);
      chk("perf_drain_toggle", 64'(dsc), 64'd0);
`endif
      do_run(1, 1'b0, 2, 3, 1'b0, 24);
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
      chk("perf_fill_stall", 64'(fsc), 64'd0);
      chk("perf_drain_stall", 64'(dsc), 64'd3);
`endif
      do_run(1, 1'b0, 0, 0, 1'b1, 21);

      // Abort in tile 1, column 2.
      start     = 1'b1;
      num_tiles = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (tile_idx == 8'd1 && wif.col_wen == 4'b0100) begin
            found = 1'b1;
            rst   = 1'b1;
         end
         @(posedge clk); #1;
      end
      chk("abort_point_found", 64'(found), 64'd1);
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_in_ready", 64'(wif.in_ready), 64'd0);
      chk("abort_col_wen", 64'(wif.col_wen), 64'd0);
      chk("abort_fifo_en", 64'(wif.fifo_en), 64'd0);
      chk("abort_w_wen", 64'(wif.w_wen), 64'd0);
      chk("abort_tile_idx", 64'(tile_idx), 64'd0);
      chk("abort_row_idx", 64'(wif.row_idx), 64'd0);
`ifdef WEIGHT_FIFO_SEQ_PERF_EN
      chk("abort_perf_fill", 64'(fsc), 64'd0);
`endif
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("abort_no_done", 64'(done), 64'd0);
         @(posedge clk); #1;
      end
      do_run(1, 1'b0, 0, 0, 1'b0, 21);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
